shader_instr_dispatcher: RTL and testbench

SHADER_INSTR_DISPATCHER -- requirements
Module: shader_instr_dispatcher

---
 rtl/shader_instr_dispatcher.sv | 140 ++++++++++++++
 tb/tb_shader_instr_dispatcher.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_instr_dispatcher.sv
// Program-memory backed instruction dispatcher: fetches words from a local program RAM and
// issues them to the shader core over a valid/ready handshake. DISPATCH_PERF_EN adds counters.
module shader_instr_dispatcher #(
  parameter int unsigned PROG_DEPTH = 256,
  parameter int unsigned ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_wdata,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [15:0]       instr_len,
  input  logic              abort,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]       issued_count,
  output logic [31:0]       stall_cycles,
`endif
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDone} state_e;

  localparam logic [4:0] OpEnd = 5'b11111;

  logic [31:0]       mem_q [PROG_DEPTH];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Program RAM is never reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && state_q == StIdle) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    remaining_d = remaining_q;
    instr_d     = instr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (instr_len != 16'd0) begin
            pc_d        = start_pc;
            remaining_d = instr_len;
            state_d     = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StDone;
        end else begin
          instr_d = mem_q[pc_q];
          state_d = StIssue;
        end
      end
      StIssue: begin
        // abort wins over a simultaneous ready
        if (abort) begin
          state_d = StDone;
        end else if (instr_ready) begin
          remaining_d = remaining_q - 16'd1;
          pc_d        = pc_q + ADDR_W'(1);
          state_d     = (remaining_q == 16'd1 || instr_q[31:27] == OpEnd) ? StDone : StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    valid_d = (state_d == StIssue);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      remaining_q <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      remaining_q <= remaining_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef DISPATCH_PERF_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (state_q == StIssue && instr_ready && !abort) issued_d = issued_q + 32'd1;
    if (valid_q && !instr_ready) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign issued_count = issued_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_shader_instr_dispatcher.sv
// Bench for shader_instr_dispatcher: directed programs plus a queue-based model of the
// expected instruction stream checked every cycle. Define DISPATCH_PERF_EN to cover the counters.
module tb_shader_instr_dispatcher;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_wdata = '0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [15:0]   instr_len = '0;
  logic          abort = 1'b0;
  logic          instr_ready = 1'b0;
  logic [31:0]   instruction;
  logic          instr_valid, busy, done;
`ifdef DISPATCH_PERF_EN
  logic [31:0]   issued_count, stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  shader_instr_dispatcher #(.PROG_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .start       (start),
    .start_pc    (start_pc),
    .instr_len   (instr_len),
    .abort       (abort),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
`ifdef DISPATCH_PERF_EN
    .issued_count(issued_count),
    .stall_cycles(stall_cycles),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mirrors program memory, expands each accepted start into the list of words that
  // must be issued, and derives done/hold/bubble/counter expectations from the rules.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic        done_exp = 1'b0;
  logic        hs_prev = 1'b0;
  logic        nxt_done;
  logic [31:0] last_instr = '0;
  logic [31:0] exp_issued = '0;
  logic [31:0] exp_stall = '0;
  logic [31:0] w;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      done_exp   = 1'b0;
      hs_prev    = 1'b0;
      last_instr = '0;
      exp_issued = '0;
      exp_stall  = '0;
    end else begin
      chk1("m_done", done, done_exp);
      if (hs_prev) chk1("m_bubble", instr_valid, 1'b0);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL m_unexpected_valid: got valid=1 instr 0x%08h, expected valid=0 at %0t",
                   instruction, $time);
        end else begin
          chk32("m_instr", instruction, exp_q[0]);
        end
      end else begin
        chk32("m_hold", instruction, last_instr);
      end
`ifdef DISPATCH_PERF_EN
      chk32("m_issued", issued_count, exp_issued);
      chk32("m_stall", stall_cycles, exp_stall);
`endif
      nxt_done = 1'b0;
      hs_prev  = 1'b0;
      if (instr_valid && !instr_ready) exp_stall++;
      if (busy && !done && abort) begin
        exp_q.delete();
        nxt_done = 1'b1;
      end else if (instr_valid && instr_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_issued++;
        hs_prev = 1'b1;
        if (exp_q.size() == 0) nxt_done = 1'b1;
      end
      if (!busy && prog_we) m_mem[prog_addr] = prog_wdata;
      if (!busy && start) begin
        if (instr_len == 16'd0) begin
          nxt_done = 1'b1;
        end else begin
          for (int i = 0; i < int'(instr_len); i++) begin
            w = m_mem[(int'(start_pc) + i) % DEPTH];
            exp_q.push_back(w);
            if (w[31:27] == 5'b11111) break;
          end
        end
      end
      done_exp   = nxt_done;
      last_instr = instruction;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = AW'(a);
    prog_wdata = d;
    step();
    prog_we = 1'b0;
  endtask

  // Returns one cycle after the start cycle.
  task automatic go(input int pc, input int len);
    start     = 1'b1;
    start_pc  = AW'(pc);
    instr_len = 16'(len);
    step();
    start = 1'b0;
  endtask

  // Always-ready run issuing n words: valid on even cycles 2..2n, done on 2n+1.
  task automatic run_ready(input string nm, input int pc, input int len, input int n,
                           input logic [31:0] wv [4]);
    instr_ready = 1'b1;
    go(pc, len);
    for (int t = 1; t <= 2 * n + 2; t++) begin
      if (t > 1) step();
      chk1({nm, "_valid"}, instr_valid, (t % 2 == 0) && (t <= 2 * n));
      if ((t % 2 == 0) && (t <= 2 * n)) chk32({nm, "_instr"}, instruction, wv[t / 2 - 1]);
      chk1({nm, "_done"}, done, t == 2 * n + 1);
      chk1({nm, "_busy"}, busy, t <= 2 * n + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  int  issues;
  logic seen_done;

  initial begin
    step();
    step();
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_instr", instruction, 32'h0);
    rst = 1'b0;
    step();

    // In-order issue at one per two cycles.
    for (int i = 0; i < 4; i++) wr(i, 32'h0A000001 + 32'(i));
    run_ready("basic", 0, 4, 4, '{32'h0A000001, 32'h0A000002, 32'h0A000003, 32'h0A000004});

    // Backpressure on the first instruction for five cycles.
    instr_ready = 1'b0;
    go(0, 3);
    step();
    for (int k = 0; k < 5; k++) begin
      chk1("stall_valid", instr_valid, 1'b1);
      chk32("stall_instr", instruction, 32'h0A000001);
      step();
    end
    chk1("stall_valid6", instr_valid, 1'b1);
    chk32("stall_instr6", instruction, 32'h0A000001);
    instr_ready = 1'b1;
    issues    = 1;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (instr_valid) issues++;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    chk32("stall_issues", 32'(issues), 32'd3);
    chk1("stall_done_seen", seen_done, 1'b1);
    step();
    chk1("stall_idle", busy, 1'b0);
`ifdef DISPATCH_PERF_EN
    chk32("stall_cycles_lit", stall_cycles, 32'd5);
    chk32("stall_issued_lit", issued_count, 32'd7);
`endif

    // Address wrap from the last word to word 0.
    wr(DEPTH - 1, 32'h11111111);
    wr(0, 32'h22222222);
    run_ready("wrap", DEPTH - 1, 2, 2, '{32'h11111111, 32'h22222222, 32'h0, 32'h0});

    // END opcode terminates early; counters start from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr(4, 32'h0A000005);
    wr(5, 32'hF8000000);
    run_ready("endop", 4, 10, 2, '{32'h0A000005, 32'hF8000000, 32'h0, 32'h0});
`ifdef DISPATCH_PERF_EN
    chk32("endop_issued", issued_count, 32'd2);
`endif

    // Abort while stalled in issue; a second start mid-run is ignored.
    instr_ready = 1'b0;
    go(0, 3);
    step();
    chk1("abort_valid_t2", instr_valid, 1'b1);
    chk32("abort_instr_t2", instruction, 32'h22222222);
    start     = 1'b1;
    start_pc  = AW'(5);
    instr_len = 16'd1;
    step();
    start = 1'b0;
    chk1("abort_valid_t3", instr_valid, 1'b1);
    chk32("abort_instr_t3", instruction, 32'h22222222);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk1("abort_valid_t4", instr_valid, 1'b0);
    chk1("abort_done_t4", done, 1'b1);
    chk32("abort_instr_t4", instruction, 32'h22222222);
    step();
    chk1("abort_done_t5", done, 1'b0);
    chk1("abort_busy_t5", busy, 1'b0);
    step();
    chk1("abort_busy_t6", busy, 1'b0);
`ifdef DISPATCH_PERF_EN
    chk32("abort_issued", issued_count, 32'd2);
    chk32("abort_stall", stall_cycles, 32'd2);
`endif

    // Zero-length launch goes straight to done.
    go(0, 0);
    chk1("zero_done", done, 1'b1);
    chk1("zero_busy", busy, 1'b1);
    chk1("zero_valid", instr_valid, 1'b0);
    step();
    chk1("zero_done2", done, 1'b0);
    chk1("zero_busy2", busy, 1'b0);

    // Reset mid-program, then rerun the retained program.
    instr_ready = 1'b1;
    go(0, 4);
    step();
    chk32("rstmid_instr_t2", instruction, 32'h22222222);
    rst = 1'b1;
    step();
    chk1("rstmid_valid", instr_valid, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_done", done, 1'b0);
    chk32("rstmid_instr", instruction, 32'h0);
`ifdef DISPATCH_PERF_EN
    chk32("rstmid_issued", issued_count, 32'd0);
    chk32("rstmid_stall", stall_cycles, 32'd0);
`endif
    rst = 1'b0;
    step();
    chk1("rstmid_nodone", done, 1'b0);
    chk1("rstmid_idle", busy, 1'b0);
    run_ready("rerun", 0, 4, 4, '{32'h22222222, 32'h0A000002, 32'h0A000003, 32'h0A000004});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
